// File: rtl/fetch_unit_l2_pkg.sv
// FetchPkg: types and constants shared by the fetch unit and its FIFOs.
//   inflight_entry_t : one issued-but-unanswered memory request
//   fbuf_entry_t     : one returned instruction waiting for decode
//   FETCH_PC_INCR    : byte stride between sequential fetches
package FetchPkg;

  localparam logic [31:0] FETCH_PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        squashed;
  } inflight_entry_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fbuf_entry_t;

endpackage

// File: rtl/fetch_unit_l2_fifo.sv
// fetch_fifo: synchronous FIFO, parameterised on depth (power of 2) and
// entry type, with a per-entry tag bit that can be set on every entry at
// once (squash_all_i). New entries are pushed with the tag clear.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i         write push_data_i at the tail (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   head_o         head entry data
//   head_tag_o     head entry tag bit
//   flush_i        discard all entries
//   squash_all_i   set the tag of every stored entry
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries
module fetch_fifo #(
  parameter int unsigned p_depth = 4,
  parameter type T = logic [31:0],
  localparam int unsigned AW = $clog2(p_depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          head_tag_o,
  input  logic          flush_i,
  input  logic          squash_all_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(p_depth);

  T                   mem_q [p_depth];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [p_depth-1:0] tag_q, tag_d;
  logic               push_ok, pop_ok;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_o     = mem_q[rd_ptr_q];
  assign head_tag_o = tag_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // Squash marks everything present at this edge; an entry pushed in the
    // same cycle is newer than the squash and stays clean.
    if (squash_all_i) tag_d = '1;
    if (push_ok)      tag_d[wr_ptr_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit_l2.sv
// fetch_unit_l2: in-order instruction fetch stage feeding decode.
// Issues sequential word fetches to instruction memory, tracks them in an
// in-flight FIFO, buffers returned words and hands {inst, pc, seq_num} to
// decode. A redirect squashes outstanding work and restarts at a new PC;
// commit notifications bound the number of live sequence numbers.
//
// Optional build macro FETCH_BYPASS_EN: an unsquashed response arriving
// while the response buffer is empty is offered to decode in the same
// cycle and is not buffered if decode takes it.
//
// Handshakes: every channel (mem_req, mem_resp, f) transfers on a cycle in
// which both val and rdy are high at the rising clock edge; val never
// depends on rdy of the same channel.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_req_val/rdy, mem_req_addr    fetch request channel
//   mem_resp_val/rdy, mem_resp_data  in-order response channel
//   f_val/rdy, f_inst, f_pc, f_seq_num  instruction channel to decode
//   redirect_val, redirect_pc        squash and restart
//   commit_val                       one instruction committed
module fetch_unit_l2
  import FetchPkg::*;
#(
  parameter logic [31:0] p_reset_pc     = 32'h200,
  parameter int unsigned p_max_inflight = 4,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [31:0]               mem_req_addr,
  input  logic                      mem_resp_val,
  output logic                      mem_resp_rdy,
  input  logic [31:0]               mem_resp_data,
  output logic                      f_val,
  input  logic                      f_rdy,
  output logic [31:0]               f_inst,
  output logic [31:0]               f_pc,
  output logic [p_seq_num_bits-1:0] f_seq_num,
  input  logic                      redirect_val,
  input  logic [31:0]               redirect_pc,
  input  logic                      commit_val
);

  localparam int unsigned CW = $clog2(p_max_inflight) + 1;
  localparam logic [CW:0] MAX_OCC = (CW+1)'(p_max_inflight);
  localparam logic [p_seq_num_bits-1:0] SEQ_ONE = 1;
  localparam logic [p_seq_num_bits:0]   UNC_ONE = 1;

  logic [31:0]               pc_q, pc_d;
  logic [p_seq_num_bits-1:0] seq_q, seq_d;
  logic [p_seq_num_bits:0]   unc_q, unc_d;

  inflight_entry_t if_push, if_head;
  logic            if_tag, if_full, if_empty;
  logic [CW-1:0]   if_count;
  fbuf_entry_t     fb_push_data, fb_head;
  logic            fb_tag, fb_full, fb_empty;
  logic [CW-1:0]   fb_count;

  logic [CW:0] occupancy;
  logic        req_fire, resp_fire, resp_keep, dec_fire;
  logic        fb_push, fb_pop, unc_ok;

  // Credits: every issued request owns a slot until decode takes it, so a
  // response can always be buffered and the response side never stalls.
  assign occupancy    = {1'b0, if_count} + {1'b0, fb_count};
  assign mem_req_val  = !rst && (occupancy < MAX_OCC) && !redirect_val;
  assign mem_req_addr = pc_q;
  assign mem_resp_rdy = 1'b1;

  assign req_fire  = mem_req_val && mem_req_rdy;
  assign resp_fire = mem_resp_val && mem_resp_rdy;
  assign resp_keep = resp_fire && !(if_head.squashed || if_tag) && !redirect_val;

  // Top bit of the uncommitted count set means all seq nums are live.
  assign unc_ok    = !unc_q[p_seq_num_bits];
  assign f_seq_num = seq_q;
  assign dec_fire  = f_val && f_rdy;

  assign if_push      = '{pc: pc_q, squashed: 1'b0};
  assign fb_push_data = '{inst: mem_resp_data, pc: if_head.pc};

`ifdef FETCH_BYPASS_EN
  always_comb begin
    f_val   = !rst && !redirect_val && unc_ok && (!fb_empty || resp_keep);
    f_inst  = fb_empty ? mem_resp_data : fb_head.inst;
    f_pc    = fb_empty ? if_head.pc    : fb_head.pc;
    // A bypassed word that decode accepted never enters the buffer.
    fb_push = resp_keep && !(fb_empty && dec_fire);
    fb_pop  = dec_fire && !fb_empty;
  end
`else
  always_comb begin
    f_val   = !rst && !redirect_val && unc_ok && !fb_empty;
    f_inst  = fb_head.inst;
    f_pc    = fb_head.pc;
    fb_push = resp_keep;
    fb_pop  = dec_fire;
  end
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_val)  pc_d = redirect_pc;
    else if (req_fire) pc_d = pc_q + FETCH_PC_INCR;

    seq_d = dec_fire ? seq_q + SEQ_ONE : seq_q;

    unique case ({dec_fire, commit_val})
      2'b10:   unc_d = unc_q + UNC_ONE;
      2'b01:   unc_d = unc_q - UNC_ONE;
      default: unc_d = unc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= p_reset_pc;
      seq_q <= '0;
      unc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      seq_q <= seq_d;
      unc_q <= unc_d;
    end
  end

  fetch_fifo #(.p_depth(p_max_inflight), .T(inflight_entry_t)) u_inflight (
    .clk          (clk),
    .rst          (rst),
    .push_i       (req_fire),
    .push_data_i  (if_push),
    .pop_i        (resp_fire),
    .head_o       (if_head),
    .head_tag_o   (if_tag),
    .flush_i      (1'b0),
    .squash_all_i (redirect_val),
    .full_o       (if_full),
    .empty_o      (if_empty),
    .count_o      (if_count)
  );

  fetch_fifo #(.p_depth(p_max_inflight), .T(fbuf_entry_t)) u_fbuf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fb_push),
    .push_data_i  (fb_push_data),
    .pop_i        (fb_pop),
    .head_o       (fb_head),
    .head_tag_o   (fb_tag),
    .flush_i      (redirect_val),
    .squash_all_i (1'b0),
    .full_o       (fb_full),
    .empty_o      (fb_empty),
    .count_o      (fb_count)
  );

  a_commit_underflow: assert property (@(posedge clk) disable iff (rst)
    !(commit_val && unc_q == '0))
    else $error("commit_val with no uncommitted instruction");

  a_resp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(mem_resp_val && if_empty))
    else $error("memory response with nothing in flight");

  a_inflight_overrun: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && if_full))
    else $error("request issued with in-flight FIFO full");

  a_fbuf_overrun: assert property (@(posedge clk) disable iff (rst)
    !(fb_push && fb_full))
    else $error("response buffer overrun");

  a_fbuf_tag_clear: assert property (@(posedge clk) disable iff (rst)
    !(fb_tag && !fb_empty))
    else $error("response buffer entry tagged");

endmodule
